jedro_1_dmem_ctrl: RTL and testbench
====================================

Name: jedro_1_dmem_ctrl

Overview:
Data-memory slave that sits directly downstream of the load-store unit, on its data request and data response interfaces. It accepts one request at a time over a valid/ready handshake and performs byte-lane placement. It accesses a word-organised on-chip RAM after a configurable number of wait states. It returns read data or a bus error on the response interface.

Parameters:
DATA_WIDTH, 32, data/address width; fixed at 32, width rules below assume it.
MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
ADDR_BASE, 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*4.
WAIT_STATES, 0, extra cycles between acceptance and response; range 0..15.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  asynchronous, active-high reset.
req_addr_i  in  32  byte address.
req_data_i  in  32  store data, LSB-aligned (lane 0).
req_strobe_i  in  4  size mask at lane 0: 0001 byte, 0011 half, 1111 word.
req_write_i  in  1  1 = store, 0 = load.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request accepted when valid && ready.
rsp_data_o  out  32  load data, LSB-aligned; 0 for stores and errors.
rsp_error_o  out  1  bus error for this response.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response consumed when valid && ready.

Behaviour:
- Reset (async, rst_i=1): state IDLE, rsp_valid_o=0, rsp_error_o=0, rsp_data_o=0, wait counter 0. req_ready_o=1 after release. RAM contents are not reset. Reset mid-transaction drops the pending request and its response.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready_o=1. On accept, go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: load counter with WAIT_STATES-1 on accept, decrement each cycle; go to RESP when it reaches 0.
  - RESP: rsp_valid_o=1, all response outputs held stable until rsp_ready_i. On fire, go to IDLE.
- Pipelined acceptance: req_ready_o = IDLE || (RESP && rsp_ready_i). This path is combinational from rsp_ready_i. A request accepted in the same cycle as a response fire follows the IDLE-accept transitions.
- Throughput: one response per cycle when WAIT_STATES=0 and rsp_ready_i is held high.
- Latency: accept at edge N gives rsp_valid_o from cycle N+1+WAIT_STATES.
- Capture: address, data, strobe and write flag are registered at accept; inputs are ignored afterwards.
- Address decode: off = req_addr_i[1:0]; word index = (addr-ADDR_BASE)>>2.
  - Out of range (addr < ADDR_BASE or index >= MEM_WORDS) gives rsp_error_o=1, rsp_data_o=0 and no RAM write.
- Lane placement: lane mask = (strobe<<off)[3:0]; write word = data<<(8*off).
  - Store: writes only the masked bytes.
  - Load: rsp_data_o = word>>(8*off), then bytes outside strobe forced to 0 (sign extension is not done here).
- RAM access happens on the cycle entering RESP.
  - Store: rsp_data_o=0, rsp_error_o=0.
  - strobe=0000: no-op, success.
- Load after store to the same address returns the new data; the store completes before its response.
- Boundary addresses ADDR_BASE and ADDR_BASE+MEM_WORDS*4-1 are valid; the next byte is an error.

Optional Feature:
JEDRO_1_DMEM_MISALIGN_ERR_EN
- Defined: an access whose (strobe<<off) sets any bit above bit 3 (e.g. word at off≠0, half at off=3) gives rsp_error_o=1, rsp_data_o=0 and no RAM write.
- Undefined: such an access is truncated at the word boundary. Bytes beyond lane 3 are dropped on store and read as 0 on load. rsp_error_o=0.

Decomposition:
- Shared package jedro_1_defines gets:
  - dmem_state_e (IDLE, WAIT, RESP);
  - the strobe constants STRB_BYTE=4'b0001, STRB_HALF=4'b0011, STRB_WORD=4'b1111.
- DATA_WIDTH is reused from the package.
- One sub-module, jedro_1_ram_sp: single-port, synchronous-write, byte-enabled RAM of MEM_WORDS x 32, with write-first read.
- Lane shifting and range check stay in jedro_1_dmem_ctrl.

Test Plan:
- Word store then load, WAIT_STATES=0, rsp_ready_i=1: store 0xDEADBEEF at 0x10, then load 0x10. Expect responses at N+1 and N+2, load data 0xDEADBEEF, error 0; back-to-back accept with no bubble.
- Byte lanes: word store 0x11223344 at 0x20; byte store 0xAA at 0x22; half load 0x22. Expect 0x000011AA. Byte load 0x23 gives 0x00000011.
- Out of range, MEM_WORDS=1024: load 0x1000. Expect rsp_error_o=1, data 0. Word store at 0xFFC succeeds; load 0xFFC returns the stored value.
- Backpressure, WAIT_STATES=3: accept load at edge N, rsp_valid_o rises at N+4; hold rsp_ready_i=0 for 5 cycles. Expect outputs stable and req_ready_o=0 throughout; on release, a new request is accepted in the same cycle.
- Misaligned word store 0xCAFEF00D at 0x41 (off=1):
  - macro defined: error, RAM word 0x40 unchanged;
  - macro undefined: RAM word 0x40 bytes [3:1] = 0xFEF00D, byte 0 unchanged, error 0.
- Reset mid-WAIT: assert rst_i during WAIT. Expect rsp_valid_o=0 immediately (asynchronous), no response after release, req_ready_o=1, and RAM contents preserved.

Source files
------------

// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 data-memory path: controller states,
// access-size strobes and the datapath width.
package jedro_1_defines;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/jedro_1_dmem_ctrl_if.sv
// Request/response bus between the load-store unit (master) and the
// data-memory controller (slave).
interface jedro_1_dmem_ctrl_if;
  import jedro_1_defines::*;

  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic [3:0]            req_strobe_i;
  logic                  req_write_i;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic                  rsp_error_o;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;

  modport slave (
    input  req_addr_i, req_data_i, req_strobe_i, req_write_i, req_valid_i, rsp_ready_i,
    output req_ready_o, rsp_data_o, rsp_error_o, rsp_valid_o
  );

  modport master (
    output req_addr_i, req_data_i, req_strobe_i, req_write_i, req_valid_i, rsp_ready_i,
    input  req_ready_o, rsp_data_o, rsp_error_o, rsp_valid_o
  );

endinterface

// File: rtl/jedro_1_ram_sp.sv
// Single-port word RAM with per-byte write enables; the read port returns
// the freshly written bytes when read and write hit the same word.
module jedro_1_ram_sp import jedro_1_defines::*; #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          r_rdata[8*b +: 8]       <= wdata_i[8*b +: 8];
        end else begin
          r_rdata[8*b +: 8]       <= r_mem[addr_i][8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/jedro_1_dmem_ctrl.sv
// Data-memory slave: one outstanding access, byte-lane placement, range check.
// Optional JEDRO_1_DMEM_MISALIGN_ERR_EN turns word-crossing accesses into bus errors.
module jedro_1_dmem_ctrl import jedro_1_defines::*; #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  jedro_1_dmem_ctrl_if.slave bus
);

  localparam int         AW      = $clog2(MEM_WORDS);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);
`ifdef JEDRO_1_DMEM_MISALIGN_ERR_EN
  localparam logic MISALIGN_ERR = 1'b1;
`else
  localparam logic MISALIGN_ERR = 1'b0;
`endif

  dmem_state_e           r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_addr, r_data;
  logic [3:0]            r_strb;
  logic                  r_write;
  logic                  r_rsp_err, r_rsp_rd;
  logic [1:0]            r_rsp_off;
  logic [3:0]            r_rsp_strb;

  logic                  w_acc, w_fire, w_enter;
  logic [DATA_WIDTH-1:0] w_addr, w_data, w_wdata, w_rdata, w_ld_shift, w_ld_data;
  logic [3:0]            w_strb, w_we;
  logic                  w_write, w_oor, w_mis, w_err;
  logic [29:0]           w_idx;
  logic [7:0]            w_lane8;

  assign bus.req_ready_o = (r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready_i);
  assign w_fire          = (r_state == RESP) && bus.rsp_ready_i;
  assign w_acc           = bus.req_valid_i && bus.req_ready_o;

  // With no wait states the RAM is accessed on the accept edge, straight from the bus.
  assign w_addr  = (WAIT_STATES == 0) ? bus.req_addr_i   : r_addr;
  assign w_data  = (WAIT_STATES == 0) ? bus.req_data_i   : r_data;
  assign w_strb  = (WAIT_STATES == 0) ? bus.req_strobe_i : r_strb;
  assign w_write = (WAIT_STATES == 0) ? bus.req_write_i  : r_write;

  assign w_idx   = w_addr[31:2] - ADDR_BASE[31:2];
  assign w_oor   = (w_addr < ADDR_BASE) || (w_idx >= 30'(MEM_WORDS));
  assign w_lane8 = {4'b0000, w_strb} << w_addr[1:0];
  assign w_mis   = |w_lane8[7:4];
  assign w_err   = w_oor || (MISALIGN_ERR && w_mis);
  assign w_we    = (w_enter && w_write && !w_err) ? w_lane8[3:0] : 4'b0000;
  assign w_wdata = w_data << {w_addr[1:0], 3'b000};

  jedro_1_ram_sp #(.MEM_WORDS(MEM_WORDS)) u_ram (
    .clk_i   (clk_i),
    .en_i    (w_enter),
    .we_i    (w_we),
    .addr_i  (w_idx[AW-1:0]),
    .wdata_i (w_wdata),
    .rdata_o (w_rdata)
  );

  // Next state; a request accepted while a response fires restarts from the IDLE rules.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter     = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        if (w_acc) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = RESP;
            w_enter     = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WS_LOAD;
          end
        end else if (w_fire) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
          w_enter     = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_strb     <= 4'd0;
      r_write    <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_rd   <= 1'b0;
      r_rsp_off  <= 2'd0;
      r_rsp_strb <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc) begin
        r_addr  <= bus.req_addr_i;
        r_data  <= bus.req_data_i;
        r_strb  <= bus.req_strobe_i;
        r_write <= bus.req_write_i;
      end
      if (w_enter) begin
        r_rsp_err  <= w_err;
        r_rsp_rd   <= !w_write && !w_err;
        r_rsp_off  <= w_addr[1:0];
        r_rsp_strb <= w_strb;
      end
    end
  end

  // Load data realigned to lane 0; lanes outside the access size read as zero.
  always_comb begin
    w_ld_shift = w_rdata >> {r_rsp_off, 3'b000};
    w_ld_data  = 32'd0;
    for (int b = 0; b < 4; b++) begin
      w_ld_data[8*b +: 8] = r_rsp_strb[b] ? w_ld_shift[8*b +: 8] : 8'd0;
    end
  end

  assign bus.rsp_valid_o = (r_state == RESP);
  assign bus.rsp_error_o = (r_state == RESP) && r_rsp_err;
  assign bus.rsp_data_o  = ((r_state == RESP) && r_rsp_rd) ? w_ld_data : 32'd0;

endmodule

// File: tb/tb_jedro_1_dmem_ctrl.sv
// Scoreboard bench for jedro_1_dmem_ctrl: one instance with no wait states and
// one with three, checked against a byte-addressed reference memory.
module tb_jedro_1_dmem_ctrl;
  import jedro_1_defines::*;

  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h0000_0000;
`ifdef JEDRO_1_DMEM_MISALIGN_ERR_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    bit          exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   rnd0 = 1'b0;
  exp_t q0[$];
  exp_t q3[$];
  logic [7:0] mem_m [longint];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jedro_1_dmem_ctrl_if if0 ();
  jedro_1_dmem_ctrl_if if3 ();

  jedro_1_dmem_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_BASE(BASE), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0)
  );
  jedro_1_dmem_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_BASE(BASE), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(if3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: the RAM as individual bytes, accesses applied in acceptance order.
  function automatic exp_t model(input int inst, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic w);
    exp_t   e;
    int     off;
    longint key;
    off    = int'(a[1:0]);
    e.data = 32'd0;
    e.err  = (a < BASE) || (a >= BASE + 32'(MEM_WORDS * 4));
    e.acc  = 0;
    e.exact = 1'b0;
    for (int i = 0; i < 4; i++)
      if (s[i] && (off + i > 3) && MIS_EN) e.err = 1'b1;
    if (!e.err) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] && (off + i <= 3)) begin
          key = (longint'(inst) << 32) | longint'(a + 32'(i));
          if (w) mem_m[key] = d[8*i +: 8];
          else e.data[8*i +: 8] = mem_m.exists(key) ? mem_m[key] : 8'h00;
        end
      end
    end
    if (w) e.data = 32'd0;
    return e;
  endfunction

  task automatic drive(input int inst, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w, input logic v);
    if (inst == 0) begin
      if0.req_addr_i = a; if0.req_data_i = d; if0.req_strobe_i = s;
      if0.req_write_i = w; if0.req_valid_i = v;
    end else begin
      if3.req_addr_i = a; if3.req_data_i = d; if3.req_strobe_i = s;
      if3.req_write_i = w; if3.req_valid_i = v;
    end
  endtask

  task automatic issue(input int inst, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w, input bit exact, output int tries);
    exp_t e;
    bit   done = 1'b0;
    tries = 0;
    drive(inst, a, d, s, w, 1'b1);
    while (!done && tries < 200) begin
      @(negedge clk);
      if ((inst == 0) ? if0.req_ready_o : if3.req_ready_o) begin
        e = model(inst, a, d, s, w);
        e.acc = cyc + 1;
        e.exact = exact;
        if (inst == 0) q0.push_back(e); else q3.push_back(e);
        done = 1'b1;
      end else begin
        tries++;
      end
      @(posedge clk); #1;
    end
    drive(inst, a, d, s, w, 1'b0);
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout inst%0d addr %h: no ready seen, ready required", inst, a);
    end
  endtask

  task automatic go(input int inst, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic w, input bit exact);
    int t;
    issue(inst, a, d, s, w, exact, t);
  endtask

  task automatic drain(input int inst);
    int k = 0;
    while (((inst == 0) ? q0.size() : q3.size()) != 0 && k < 300) begin
      @(negedge clk); k++;
    end
    @(posedge clk); #1;
    if (((inst == 0) ? q0.size() : q3.size()) != 0) begin
      n_chk++;
      $display("FAIL drain_timeout inst%0d: %0d responses outstanding, 0 required", inst,
               (inst == 0) ? q0.size() : q3.size());
    end
  endtask

  // Monitor: every fired response is compared against the oldest expectation.
  task automatic mon(input int inst);
    exp_t e;
    logic v, r, er;
    logic [31:0] d;
    int ws;
    ws = (inst == 0) ? 0 : 3;
    forever begin
      @(negedge clk);
      if (inst == 0) begin v = if0.rsp_valid_o; r = if0.rsp_ready_i; d = if0.rsp_data_o; er = if0.rsp_error_o; end
      else begin v = if3.rsp_valid_o; r = if3.rsp_ready_i; d = if3.rsp_data_o; er = if3.rsp_error_o; end
      if (v && r) begin
        if (((inst == 0) ? q0.size() : q3.size()) == 0) begin
          n_chk++;
          $display("FAIL rsp%0d_unexpected: got response data %h err %b, expected none", inst, d, er);
        end else begin
          if (inst == 0) e = q0.pop_front(); else e = q3.pop_front();
          check($sformatf("rsp%0d_data", inst), d, e.data);
          check($sformatf("rsp%0d_err", inst), {31'd0, er}, {31'd0, e.err});
          if (e.exact) check($sformatf("rsp%0d_latency", inst), cyc, e.acc + ws);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(3);

  // Response backpressure for instance 0: random in the random phase, else always ready.
  initial begin
    if0.rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if0.rsp_ready_i = rnd0 ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, finish required");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, snap;
    logic [3:0]  s;
    int          t, sel;
    drive(0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    drive(3, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    if3.rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid0", {31'd0, if0.rsp_valid_o}, 32'd0);
    check("reset_err0", {31'd0, if0.rsp_error_o}, 32'd0);
    check("reset_data0", if0.rsp_data_o, 32'd0);
    check("reset_valid3", {31'd0, if3.rsp_valid_o}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("reset_ready0", {31'd0, if0.req_ready_o}, 32'd1);
    check("reset_ready3", {31'd0, if3.req_ready_o}, 32'd1);
    @(posedge clk); #1;

    // Known contents for every word the later traffic can touch.
    for (int i = 0; i < 32; i++) go(0, 32'(4 * i), $urandom, STRB_WORD, 1'b1, 1'b1);
    for (int i = 0; i < 32; i++) go(0, 32'hF80 + 32'(4 * i), $urandom, STRB_WORD, 1'b1, 1'b1);
    drain(0);

    go(0, 32'h10, 32'hDEAD_BEEF, STRB_WORD, 1'b1, 1'b1);
    go(0, 32'h10, 32'd0,         STRB_WORD, 1'b0, 1'b1);
    go(0, 32'h20, 32'h1122_3344, STRB_WORD, 1'b1, 1'b1);
    go(0, 32'h22, 32'h0000_00AA, STRB_BYTE, 1'b1, 1'b1);
    go(0, 32'h22, 32'd0,         STRB_HALF, 1'b0, 1'b1);
    go(0, 32'h23, 32'd0,         STRB_BYTE, 1'b0, 1'b1);
    go(0, 32'h1000, 32'd0,       STRB_WORD, 1'b0, 1'b1);
    go(0, 32'hFFC, 32'h7654_3210, STRB_WORD, 1'b1, 1'b1);
    go(0, 32'hFFC, 32'd0,        STRB_WORD, 1'b0, 1'b1);
    go(0, 32'hFFF, 32'd0,        STRB_BYTE, 1'b0, 1'b1);
    go(0, 32'h1000, 32'h1234_5678, STRB_WORD, 1'b1, 1'b1);
    go(0, 32'h40, 32'h5566_7788, STRB_WORD, 1'b1, 1'b1);
    go(0, 32'h41, 32'hCAFE_F00D, STRB_WORD, 1'b1, 1'b1);
    go(0, 32'h40, 32'd0,         STRB_WORD, 1'b0, 1'b1);
    go(0, 32'h43, 32'd0,         STRB_HALF, 1'b0, 1'b1);
    go(0, 32'h44, 32'd0,         4'b0000,   1'b1, 1'b1);
    drain(0);

    rnd0 = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 32'($urandom_range(0, 127));
      else if (sel < 8)  a = 32'hF80 + 32'($urandom_range(0, 127));
      else if (sel == 8) a = 32'h1000 + 32'($urandom_range(0, 255));
      else               a = $urandom | 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       s = STRB_BYTE;
        1:       s = STRB_HALF;
        2:       s = STRB_WORD;
        default: s = 4'b0000;
      endcase
      go(0, a, $urandom, s, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain(0);
    rnd0 = 1'b0;

    go(3, 32'h8, 32'h1234_5678, STRB_WORD, 1'b1, 1'b1);
    go(3, 32'h8, 32'd0,         STRB_WORD, 1'b0, 1'b1);
    drain(3);

    // Backpressure on the wait-state instance.
    if3.rsp_ready_i = 1'b0;
    go(3, 32'h8, 32'd0, STRB_WORD, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ws3_valid_early", {31'd0, if3.rsp_valid_o}, 32'd0);
    end
    @(negedge clk);
    check("ws3_valid_rise", {31'd0, if3.rsp_valid_o}, 32'd1);
    @(posedge clk); #1;
    drive(3, 32'hB, 32'd0, STRB_BYTE, 1'b0, 1'b1);
    snap = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, if3.rsp_valid_o}, 32'd1);
      check("stall_data", if3.rsp_data_o, snap);
      check("stall_err", {31'd0, if3.rsp_error_o}, 32'd0);
      check("stall_req_ready", {31'd0, if3.req_ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    if3.rsp_ready_i = 1'b1;
    issue(3, 32'hB, 32'd0, STRB_BYTE, 1'b0, 1'b1, t);
    check("release_accept_same_cycle", 32'(t), 32'd0);
    drain(3);

    // Reset while the store sits in WAIT: it must vanish without touching RAM.
    drive(3, 32'h8, 32'hA5A5_A5A5, STRB_WORD, 1'b1, 1'b1);
    @(negedge clk);
    check("rstwait_ready", {31'd0, if3.req_ready_o}, 32'd1);
    @(posedge clk); #1;
    drive(3, 32'h8, 32'hA5A5_A5A5, STRB_WORD, 1'b1, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstwait_valid_async", {31'd0, if3.rsp_valid_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rstwait_no_rsp", {31'd0, if3.rsp_valid_o}, 32'd0);
    end
    check("rstwait_ready_after", {31'd0, if3.req_ready_o}, 32'd1);
    @(posedge clk); #1;
    go(3, 32'h8, 32'd0, STRB_WORD, 1'b0, 1'b1);
    go(0, 32'h20, 32'd0, STRB_WORD, 1'b0, 1'b1);
    drain(3);
    drain(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
